// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of the 16-bit pipeline.
//
// Owns the fetch PC, issues reads to the instruction memory port and loads
// the IF/ID register (pc_o, inst_o, valid_o) for decode. Branch redirects
// arrive from decode one instruction late (single delay slot); a redirect
// seen while the memory port is busy is parked until the delay slot lands.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_i             hold IF/ID and fetch PC, no request issued
//   branch_flag_i/addr  redirect from the instruction currently in ID
//   imem_req_o/addr_o   memory request (combinational), address = fetch PC
//   imem_rdata_i/ready  read data, valid when ready=1
//   pc_o/inst_o/valid_o IF/ID register
//   fetch_stall_req_o   memory wait request to ctrl
//   timeout_o           sticky: too many consecutive wait cycles
// ---------------------------------------------------------------------------
module if_fetch #(
   parameter logic [15:0] PC_RESET = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0800,
   parameter int          MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [15:0] branch_addr_i,
   output logic        imem_req_o,
   output logic [15:0] imem_addr_o,
   input  logic [15:0] imem_rdata_i,
   input  logic        imem_ready_i,
   output logic [15:0] pc_o,
   output logic [15:0] inst_o,
   output logic        valid_o,
   output logic        fetch_stall_req_o,
   output logic        timeout_o
);

   typedef enum logic {BOOT, RUN} state_t;

   localparam logic [4:0] MAX_WAIT_W = 5'(MAX_WAIT);

   state_t      state_q, state_d;
   logic [15:0] fetch_pc_q, fetch_pc_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] inst_q, inst_d;
   logic        valid_q, valid_d;
   logic        redirect_pending_q, redirect_pending_d;
   logic [15:0] redirect_addr_q, redirect_addr_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;
   logic        req;

   assign req               = (state_q == RUN) && !stall_i;
   assign imem_req_o        = req;
   assign imem_addr_o       = fetch_pc_q;
   assign fetch_stall_req_o = req && !imem_ready_i;
   assign pc_o              = pc_q;
   assign inst_o            = inst_q;
   assign valid_o           = valid_q;
   assign timeout_o         = timeout_q;

   always_comb begin
      state_d            = state_q;
      fetch_pc_d         = fetch_pc_q;
      pc_d               = pc_q;
      inst_d             = inst_q;
      valid_d            = valid_q;
      redirect_pending_d = redirect_pending_q;
      redirect_addr_d    = redirect_addr_q;
      wait_cnt_d         = wait_cnt_q;
      timeout_d          = timeout_q;

      if (state_q == BOOT) begin
         // One idle cycle after reset before the first request.
         state_d = RUN;
      end else if (!stall_i) begin
         if (imem_ready_i) begin
            inst_d  = imem_rdata_i;
            pc_d    = fetch_pc_q + 16'd1;
            valid_d = 1'b1;
            // The just-completed fetch is the delay slot of any branch in ID
            // (live or parked), so the next fetch goes to the target.
            if (branch_flag_i)
               fetch_pc_d = branch_addr_i;
            else if (redirect_pending_q)
               fetch_pc_d = redirect_addr_q;
            else
               fetch_pc_d = fetch_pc_q + 16'd1;
            redirect_pending_d = 1'b0;
            wait_cnt_d         = 4'd0;
         end else begin
            // Bubble into ID; the branch leaves ID now, so park its target.
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            if (branch_flag_i) begin
               redirect_pending_d = 1'b1;
               redirect_addr_d    = branch_addr_i;
            end
            if (wait_cnt_q != 4'hF)
               wait_cnt_d = wait_cnt_q + 4'd1;
            if (({1'b0, wait_cnt_q} + 5'd1) >= MAX_WAIT_W)
               timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= BOOT;
         fetch_pc_q         <= PC_RESET;
         pc_q               <= 16'h0000;
         inst_q             <= NOP_INST;
         valid_q            <= 1'b0;
         redirect_pending_q <= 1'b0;
         redirect_addr_q    <= 16'h0000;
         wait_cnt_q         <= 4'd0;
         timeout_q          <= 1'b0;
      end else begin
         state_q            <= state_d;
         fetch_pc_q         <= fetch_pc_d;
         pc_q               <= pc_d;
         inst_q             <= inst_d;
         valid_q            <= valid_d;
         redirect_pending_q <= redirect_pending_d;
         redirect_addr_q    <= redirect_addr_d;
         wait_cnt_q         <= wait_cnt_d;
         timeout_q          <= timeout_d;
      end
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage of the 16-bit pipeline. It owns the PC, drives requests to the instruction memory port and loads the IF/ID pipeline register (pc_o, inst_o) consumed by the decode stage. It takes branch redirects (branch_flag_i/branch_addr_i) from decode and honours the single architectural delay slot. It respects the pipeline stall from ctrl and memory wait states caused by the shared SRAM.

Parameters:
PC_RESET, 16'h0000, fetch address loaded on reset
NOP_INST, 16'h0800, encoding injected into inst_o for bubbles
MAX_WAIT, 8, consecutive wait cycles before timeout_o sets (counter width 4)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  from ctrl; 1 = hold IF/ID register and fetch PC
branch_flag_i  input  1  from decode; 1 = instruction in ID redirects flow
branch_addr_i  input  16  redirect target from decode
imem_req_o  output  1  instruction memory request (combinational)
imem_addr_o  output  16  fetch address (combinational, = fetch_pc)
imem_rdata_i  input  16  instruction word, valid when imem_ready_i=1
imem_ready_i  input  1  1 = read completes this cycle; 0 = port busy
pc_o  output  16  IF/ID register: fetch address + 1 of inst_o
inst_o  output  16  IF/ID register: instruction for decode
valid_o  output  1  IF/ID register: 1 = inst_o is a real fetch, 0 = bubble
fetch_stall_req_o  output  1  to ctrl: imem_req_o & ~imem_ready_i
timeout_o  output  1  sticky: wait count reached MAX_WAIT

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=PC_RESET, pc_o=0, inst_o=NOP_INST, valid_o=0, redirect_pending=0, redirect_addr=0, wait_cnt=0, timeout_o=0, state=BOOT.
  - Reset overrides every other input, including mid-wait and mid-redirect.
- States: BOOT, RUN.
  - BOOT: imem_req_o=0 for exactly one cycle, then RUN unconditionally.
  - RUN: imem_req_o = ~stall_i. imem_addr_o = fetch_pc in all states.
- Completed fetch (RUN, ~stall_i, imem_ready_i=1) at the edge:
  - inst_o=imem_rdata_i, pc_o=fetch_pc+1 (mod 2^16), valid_o=1.
  - fetch_pc gets the first matching value:
    1. branch_addr_i if branch_flag_i=1;
    2. else redirect_addr if redirect_pending=1;
    3. else fetch_pc+1.
  - redirect_pending cleared. wait_cnt=0.
- Wait cycle (RUN, ~stall_i, imem_ready_i=0):
  - inst_o=NOP_INST, valid_o=0, pc_o unchanged, fetch_pc unchanged, so the address is stable for the retry.
  - If branch_flag_i=1: redirect_pending=1, redirect_addr=branch_addr_i. The branch leaves ID; the next completed fetch is its delay slot, and the fetch after that goes to the target.
  - wait_cnt increments, saturating at 15. timeout_o sets when wait_cnt+1 >= MAX_WAIT and stays set until rst.
- Stall (stall_i=1, either state):
  - IF/ID register, fetch_pc, redirect state and wait_cnt all hold.
  - No request is issued and imem_rdata_i is ignored.
  - branch_flag_i is not captured while stalled; decode re-presents it after the stall releases.
- Delay slot: exactly one instruction after a taken branch is always delivered with valid_o=1, whatever the number of intervening wait cycles.
- A bubble (valid_o=0) in ID is never taken as a branch source. Decode sees NOP_INST, so branch_flag_i=0.
- fetch_pc+1 at 16'hFFFF wraps to 16'h0000, with no flag.
- fetch_stall_req_o is purely combinational and is 0 in BOOT and during stall_i.

Test Plan:
1. Reset then free-run with ready=1 and mem[i]=i+16'h1000 -> BOOT for 1 cycle; then inst_o=1000,1001,1002 on consecutive cycles, pc_o=1,2,3, valid_o=1.
2. Taken branch at addr 4 (branch_flag_i=1, branch_addr_i=16'h0020) -> inst_o sequence 4, delay slot 5, then 16'h20, with pc_o=16'h21 on the target fetch.
3. Branch at addr 4, then ready=0 for 3 cycles -> three bubbles (valid_o=0, inst_o=16'h0800), imem_addr_o held at 5; then the delay slot at 5 is delivered, then the target 16'h20.
4. stall_i=1 for 2 cycles while inst_o=addr 7 -> inst_o/pc_o hold at 7/8, imem_req_o=0; fetch resumes at 8 with no instruction skipped or duplicated.
5. ready=0 for 8 cycles -> fetch_stall_req_o=1 throughout, timeout_o=1 from the 8th edge; it stays 1 after ready returns and clears only on rst.
6. PC_RESET=16'hFFFF with ready=1 -> inst_o=mem[FFFF] with pc_o=0000, next fetch from 0000; rst asserted mid-wait with redirect_pending=1 -> all outputs return to reset values and fetch restarts at PC_RESET.
